load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-003 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- ReqValid  in  1  pipeline access request
- ReqReady  out  1  request accepted this cycle
- ReqWr  in  1  1 = store, 0 = load
- ReqCtrl  in  3  access size and sign, DMCtrl encoding
- ReqAddr  in  ADDR_W  byte address
- ReqData  in  32  store data, right-aligned
- RespValid  out  1  response available
- RespReady  in  1  response consumed
- RespData  out  32  extended load data (0 for stores)
- RespErr  out  1  misaligned or illegal access
- MemEn  out  1  memory port enable
- MemWr  out  1  memory write strobe
- MemAddr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- MemWrData  out  32  full word to write
- MemRdData  in  32  word read; valid the cycle after MemEn=1, MemWr=0

Function
REQ-004 The ReqCtrl encodings SHALL be: 000 signed byte; 001 signed half; 010 word; 100 unsigned byte; 101 unsigned half. All others are illegal.
REQ-005 Byte order SHALL be little-endian: byte n of a word is bits [8n+7:8n], with n = Addr[1:0].
REQ-006 The FSM states SHALL be IDLE, READ, WAIT, WRITE and RESP.
REQ-007 ReqReady SHALL be 1 only in IDLE; a request is accepted when ReqValid and ReqReady are both 1 at a clock edge, and all request fields are latched then.
REQ-008 The accepted request SHALL take exactly one of these paths:
- Illegal ReqCtrl, half with Addr[0]=1, or word with Addr[1:0]!=0: go to RESP with RespErr=1 and no memory access.
- Load or sub-word store: go to READ.
- Word store: go to WRITE.
REQ-009 READ SHALL drive MemEn=1 and MemWr=0 for one cycle, then go to WAIT.
REQ-010 WAIT SHALL capture MemRdData as follows:
- Load: register the extracted, extended value in RespData, then go to RESP.
- Store: register the merged word, then go to WRITE.
REQ-011 Store merge SHALL replace only the addressed byte or half with the low bits of ReqData; all other bytes are preserved.
REQ-012 WRITE SHALL drive MemEn=1, MemWr=1 and MemWrData for exactly one cycle, then go to RESP.
REQ-013 RESP SHALL hold RespValid=1; RespData and RespErr SHALL stay stable until RespReady=1, and the FSM SHALL go to IDLE on that edge.
REQ-014 Load data SHALL be sign-extended for encodings 000 and 001, zero-extended for 100 and 101, and passed through for 010.
REQ-015 Latency from the accept edge to the first RespValid=1 cycle SHALL be:
- error: 1
- word store: 2
- load: 3
- sub-word store: 4
REQ-016 MemAddr SHALL equal {latched ReqAddr[ADDR_W-1:2], 2'b00} whenever MemEn=1; MemEn and MemWr SHALL be 0 outside READ and WRITE.
REQ-017 Requests presented while ReqReady=0 SHALL be ignored; they are neither queued nor dropped silently, because ReqValid is held by the requester.
REQ-018 Exactly one memory write SHALL occur per legal store, and none per load or error.

Reset
REQ-019 rst=1 SHALL asynchronously force the state to IDLE and the outputs to ReqReady=1 (after release), RespValid=0, RespData=0, RespErr=0, MemEn=0, MemWr=0, MemAddr=0 and MemWrData=0.
REQ-020 A reset asserted mid-access (READ, WAIT, WRITE or RESP) SHALL abort the access with no response and no later memory write; a write in the same cycle as reset is not guaranteed.

Structure
REQ-021 A shared package lsu_pkg SHALL hold the ReqCtrl encoding constants and the FSM state enum.
REQ-022 The extract/extend and merge logic SHALL be one combinational sub-module, lsu_align.

Verification
REQ-023 The bench SHALL model the memory as a synchronous-read word array, with word 0x10 preloaded to 0x8899AABB, and SHALL cover:
- Load 000 at 0x11 -> RespData=0xFFFFFFAA, RespValid at accept+3, one MemEn, no MemWr.
- Load 101 at 0x12 -> RespData=0x00008899; load 010 at 0x10 -> 0x8899AABB.
- Store 000 at 0x13 with ReqData=0x1234565A -> one READ then one WRITE of 0x5A99AABB to MemAddr 0x10, RespValid at accept+4.
- Load 010 at 0x06 and ReqCtrl=011 at 0x00 -> RespErr=1 at accept+1, MemEn never 1.
- RespReady held 0 for 3 cycles -> RespValid, RespData and RespErr stable, ReqReady=0, a new ReqValid is not accepted.
- rst pulsed during WAIT of a byte store -> MemWr never asserts, RespValid=0, ReqReady=1 the cycle after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-control encodings,
// FSM state type and the request legality check.
package lsu_pkg;

  // Access size/sign encodings carried on ReqCtrl.
  localparam logic [2:0] CTRL_SB = 3'b000;  // signed byte
  localparam logic [2:0] CTRL_SH = 3'b001;  // signed half
  localparam logic [2:0] CTRL_W  = 3'b010;  // word
  localparam logic [2:0] CTRL_UB = 3'b100;  // unsigned byte
  localparam logic [2:0] CTRL_UH = 3'b101;  // unsigned half

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  // A request is legal when its encoding is known and its address is
  // naturally aligned for the access size.
  function automatic logic access_ok(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (ctrl)
      CTRL_SB, CTRL_UB: ok = 1'b1;
      CTRL_SH, CTRL_UH: ok = (addr_lo[0] == 1'b0);
      CTRL_W:           ok = (addr_lo == 2'b00);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory
// word, and merges sub-word store data into a memory word (little-endian).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [15:0] st_low,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, then extend it for loads or overwrite it for stores.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    byte_sel    = rd_word[{addr_lo, 3'b000} +: 8];
    half_sel    = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    load_data   = '0;
    merged_word = rd_word;
    case (ctrl)
      CTRL_SB: begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
        merged_word[{addr_lo, 3'b000} +: 8] = st_low[7:0];
      end
      CTRL_UB: begin
        load_data = {24'h0, byte_sel};
        merged_word[{addr_lo, 3'b000} +: 8] = st_low[7:0];
      end
      CTRL_SH: begin
        load_data = {{16{half_sel[15]}}, half_sel};
        merged_word[{addr_lo[1], 4'b0000} +: 16] = st_low;
      end
      CTRL_UH: begin
        load_data = {16'h0, half_sel};
        merged_word[{addr_lo[1], 4'b0000} +: 16] = st_low;
      end
      CTRL_W:  load_data = rd_word;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word access at a time, performs a
// read-modify-write for sub-word stores, and returns extended load data or
// an error flag through a valid/ready response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWr,
  input  logic [2:0]        ReqCtrl,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [31:0]       ReqData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [31:0]       RespData,
  output logic              RespErr,
  output logic              MemEn,
  output logic              MemWr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWrData,
  input  logic [31:0]       MemRdData
);

  lsu_state_e        state;
  logic              lat_wr;
  logic [2:0]        lat_ctrl;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_data;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic [31:0]       wr_word;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic              accept;

  assign accept = ReqValid && (state == ST_IDLE);

  lsu_align u_align (
    .ctrl        (lat_ctrl),
    .addr_lo     (lat_addr[1:0]),
    .rd_word     (MemRdData),
    .st_low      (lat_data),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Access sequencing: latch the request, route it, and hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_wr    <= 1'b0;
      lat_ctrl  <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      wr_word   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values and the block order never changes behavior.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_wr    <= ReqWr;
            lat_ctrl  <= ReqCtrl;
            lat_addr  <= ReqAddr;
            lat_data  <= ReqData[15:0];
            wr_word   <= ReqData;
            resp_data <= '0;
            if (!access_ok(ReqCtrl, ReqAddr[1:0])) begin
              resp_err <= 1'b1;
              state    <= ST_RESP;
            end else begin
              resp_err <= 1'b0;
              state    <= (ReqWr && ReqCtrl == CTRL_W) ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          if (lat_wr) begin
            wr_word <= merged_word;
            state   <= ST_WRITE;
          end else begin
            resp_data <= load_data;
            state     <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  if (RespReady) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign ReqReady  = (state == ST_IDLE);
  assign RespValid = (state == ST_RESP);
  assign RespData  = resp_data;
  assign RespErr   = resp_err && RespValid;
  assign MemEn     = (state == ST_READ) || (state == ST_WRITE);
  assign MemWr     = (state == ST_WRITE);
  assign MemAddr   = MemEn ? {lat_addr[ADDR_W-1:2], 2'b00} : '0;
  assign MemWrData = wr_word;

endmodule
